dpe_job_scheduler: RTL and testbench
====================================

# dpe_job_scheduler

Sequencer that drives a single `DotProductEngine` through a complete convolution job of `num_filters × num_patches` dot products. It sits between the layer controller and the engine. Per result it:
- selects the patch row and filter row,
- pulses the engine start,
- captures the fp32 result,
- writes it to the output buffer through a valid/ready port.

## Interface

Parameters:
- `DATA_WIDTH`, 32, fp32 result width
- `ADDR_WIDTH`, 4, engine element-address / vector-length width
- `CNT_WIDTH`, 6, patch and filter index width
- `OUT_ADDR_WIDTH`, 12, output buffer address width (= 2·CNT_WIDTH)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `job_start`  in  1  one-cycle job request
- `job_abort`  in  1  abort current job
- `num_patches`  in  CNT_WIDTH  patches per filter
- `num_filters`  in  CNT_WIDTH  filter count
- `vec_length`  in  ADDR_WIDTH  elements per dot product
- `job_busy`  out  1  job in progress
- `job_done`  out  1  one-cycle pulse, job completed
- `job_aborted`  out  1  one-cycle pulse, job aborted
- `eng_start`  out  1  engine start pulse
- `eng_vec_length`  out  ADDR_WIDTH  latched vec_length to engine
- `patch_sel`  out  CNT_WIDTH  patch row index for memory wrapper
- `filter_sel`  out  CNT_WIDTH  filter row index for memory wrapper
- `eng_done`  in  1  engine completion
- `eng_result`  in  DATA_WIDTH  engine result
- `out_valid`  out  1  result available
- `out_ready`  in  1  output buffer accepts
- `out_data`  out  DATA_WIDTH  captured result
- `out_addr`  out  OUT_ADDR_WIDTH  `filter_idx*num_patches + patch_idx`

## Operation

**FSM states:** IDLE, LAUNCH, WAIT, WRITE, FINISH.

- **IDLE**
  - `job_start` latches `num_patches`, `num_filters` and `vec_length`, and clears the indices.
  - If any latched count is 0, go to FINISH. Otherwise go to LAUNCH.
- **LAUNCH**
  - `eng_start`=1 for exactly one cycle, with `patch_sel`/`filter_sel` already stable.
  - Then go to WAIT.
- **WAIT**
  - On the first cycle with `eng_done`=1, register `eng_result` into `out_data` and go to WRITE.
- **WRITE**
  - `out_valid`=1. `out_data` and `out_addr` are held until `out_ready`=1.
  - On handshake:
    - If the last patch of the last filter, go to FINISH.
    - Else if patch_idx = num_patches−1, set patch_idx=0, increment filter_idx, go to LAUNCH.
    - Else increment patch_idx and go to LAUNCH.
- **FINISH**
  - `job_done` pulses and the FSM returns to IDLE.

**Rules:**
- Result order is filter-major (patch index inner). `out_addr` increments by 1 per result, starting at 0.
- Input config is ignored outside IDLE. `job_start` is ignored while busy.
- `job_abort` (any non-IDLE state) → IDLE on the next edge.
  - `job_aborted` pulses, `job_done` does not.
  - A pending `out_valid` is dropped.
  - Abort takes priority over a simultaneous handshake or `eng_done`.
- `job_abort` in IDLE is ignored.
- `eng_done` in states other than WAIT is ignored.
- `out_addr` is computed with a running accumulator (+1 per handshake). No multiplier.

## Timing

- All outputs are registered.
- Reset values: every output 0. Latched config and indices are also 0.
- `job_start` sampled at edge N → `job_busy` and `eng_start` high in cycle N+1.
- `eng_done` sampled at edge M → `out_valid` high in cycle M+1.
- Handshake at edge K:
  - next `eng_start` in cycle K+1, or
  - `job_done` in cycle K+1 for the last result.
- Minimum overhead per result is 3 cycles beyond engine latency. A zero-wait handshake occupies 1 WRITE cycle.
- Zero-count job: `job_done` in cycle N+2, no `eng_start`.
- `job_busy`=1 from cycle N+1 through the FINISH cycle inclusive. It deasserts with the return to IDLE.
- Reset asserted mid-job → all outputs at reset values after that edge. No `job_done`.

## Structure

- **Package `dpe_sched_pkg`:** state enum, default widths, and the `OUT_ADDR_WIDTH` derivation.
- **One natural sub-module, `dpe_index_counter`:** 2-D patch/filter counter with a `last` flag and a running output address, advanced by a single `step` input.

## Test plan

- **Basic job:** P=2, F=2, L=4; engine model returns 0x41F00000 after 6 cycles.
  - Four writes with `out_addr` 0,1,2,3.
  - sel pairs (f0,p0), (f0,p1), (f1,p0), (f1,p1).
  - `job_done` exactly once, 1 cycle after the 4th handshake.
- **Backpressure:** `out_ready` low for 5 cycles during the 2nd result.
  - `out_valid`, `out_data` and `out_addr`=1 held stable.
  - No `eng_start` until the cycle after the handshake.
- **Zero-count job:** `num_patches`=0, F=3.
  - `job_done` at N+2.
  - `eng_start` and `out_valid` never asserted.
- **Busy-time inputs:** `job_start` and changed config applied while busy.
  - Ignored; the job completes with the original P=3, F=1.
  - `out_addr` 0..2.
- **Abort:** `job_abort` in WAIT of the 2nd result.
  - `job_aborted` pulse, no `job_done`, no 2nd write.
  - A subsequent P=1, F=1 job completes at `out_addr` 0.
- **Reset mid-job:** `rst_n` low for 1 cycle during WRITE.
  - All outputs 0 at the next edge.
  - A new job afterwards runs correctly.

Source files
------------

// File: rtl/dpe_sched_pkg.sv
// dpe_sched_pkg
//   Shared definitions for the DotProductEngine job scheduler:
//   default widths, the output-address width derivation and the
//   sequencer state encoding.
package dpe_sched_pkg;

    localparam int DEF_DATA_WIDTH = 32;  // fp32 result
    localparam int DEF_ADDR_WIDTH = 4;   // engine vector length / element address
    localparam int DEF_CNT_WIDTH  = 6;   // patch / filter index

    // The output buffer holds num_filters x num_patches results, so its
    // address needs the width of both indices combined.
    function automatic int out_addr_width(input int cnt_width);
        return 2 * cnt_width;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_WRITE,
        S_FINISH
    } sched_state_e;

endpackage

// File: rtl/dpe_job_scheduler_if.sv
// dpe_job_scheduler_if
//   Valid/ready write port from the scheduler into the output buffer.
//   out_valid  master -> slave  result available
//   out_ready  slave  -> master buffer accepts this cycle
//   out_data   master -> slave  captured fp32 result
//   out_addr   master -> slave  linear result address (filter-major)
interface dpe_job_scheduler_if
    import dpe_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int OUT_ADDR_WIDTH = out_addr_width(DEF_CNT_WIDTH)
);

    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_data;
    logic [OUT_ADDR_WIDTH-1:0] out_addr;

    modport master (output out_valid, output out_data, output out_addr, input out_ready);
    modport slave  (input out_valid, input out_data, input out_addr, output out_ready);

endinterface

// File: rtl/dpe_index_counter.sv
// dpe_index_counter
//   2-D patch/filter counter for a convolution job. Patch index is the
//   inner loop. A running address counts results so no multiplier is
//   needed for filter_idx*num_patches + patch_idx.
//   clk, rst_n      clock, synchronous active-low reset
//   clear_i         zero both indices and the address
//   step_i          advance to the next (filter, patch) pair
//   num_patches_i   patches per filter (latched by the caller)
//   num_filters_i   filter count (latched by the caller)
//   patch_idx_o     current patch index
//   filter_idx_o    current filter index
//   out_addr_o      linear address of the current result
//   last_o          current pair is the final one of the job
module dpe_index_counter
    import dpe_sched_pkg::*;
#(
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int OUT_ADDR_WIDTH = out_addr_width(CNT_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_i,
    input  logic                      step_i,
    input  logic [CNT_WIDTH-1:0]      num_patches_i,
    input  logic [CNT_WIDTH-1:0]      num_filters_i,
    output logic [CNT_WIDTH-1:0]      patch_idx_o,
    output logic [CNT_WIDTH-1:0]      filter_idx_o,
    output logic [OUT_ADDR_WIDTH-1:0] out_addr_o,
    output logic                      last_o
);

    logic [CNT_WIDTH-1:0]      patch_q;
    logic [CNT_WIDTH-1:0]      filter_q;
    logic [OUT_ADDR_WIDTH-1:0] addr_q;
    logic                      patch_wrap;

    assign patch_wrap = (patch_q == num_patches_i - CNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            patch_q  <= '0;
            filter_q <= '0;
            addr_q   <= '0;
        end else if (step_i) begin
            addr_q <= addr_q + OUT_ADDR_WIDTH'(1);
            if (patch_wrap) begin
                patch_q  <= '0;
                filter_q <= filter_q + CNT_WIDTH'(1);
            end else begin
                patch_q <= patch_q + CNT_WIDTH'(1);
            end
        end
    end

    assign patch_idx_o  = patch_q;
    assign filter_idx_o = filter_q;
    assign out_addr_o   = addr_q;
    assign last_o       = patch_wrap && (filter_q == num_filters_i - CNT_WIDTH'(1));

endmodule

// File: rtl/dpe_job_scheduler.sv
// dpe_job_scheduler
//   Drives one DotProductEngine through num_filters x num_patches dot
//   products: selects rows, pulses the engine, captures each result and
//   writes it to the output buffer, filter-major.
//   clk, rst_n                 clock, synchronous active-low reset
//   job_start / job_abort      job request / abort from the layer controller
//   num_patches, num_filters,
//   vec_length                 job configuration, sampled on job_start in IDLE
//   job_busy, job_done,
//   job_aborted                job status (done/aborted are one-cycle pulses)
//   eng_start, eng_vec_length  engine launch pulse and latched vector length
//   patch_sel, filter_sel      row selects for the operand memory wrapper
//   eng_done, eng_result       engine completion and fp32 result
//   out_if                     valid/ready write port to the output buffer
module dpe_job_scheduler
    import dpe_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int OUT_ADDR_WIDTH = out_addr_width(CNT_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  job_start,
    input  logic                  job_abort,
    input  logic [CNT_WIDTH-1:0]  num_patches,
    input  logic [CNT_WIDTH-1:0]  num_filters,
    input  logic [ADDR_WIDTH-1:0] vec_length,
    output logic                  job_busy,
    output logic                  job_done,
    output logic                  job_aborted,
    output logic                  eng_start,
    output logic [ADDR_WIDTH-1:0] eng_vec_length,
    output logic [CNT_WIDTH-1:0]  patch_sel,
    output logic [CNT_WIDTH-1:0]  filter_sel,
    input  logic                  eng_done,
    input  logic [DATA_WIDTH-1:0] eng_result,
    dpe_job_scheduler_if.master   out_if
);

    sched_state_e              state_q, state_d;
    logic [CNT_WIDTH-1:0]      np_q, nf_q;
    logic [ADDR_WIDTH-1:0]     vl_q;
    logic                      busy_q, done_q, aborted_q, eng_start_q, out_valid_q;
    logic [DATA_WIDTH-1:0]     out_data_q;
    logic [OUT_ADDR_WIDTH-1:0] out_addr;
    logic                      load, step, capture, abort_hit, cnt_last;

    assign abort_hit = job_abort && (state_q != S_IDLE);
    assign capture   = (state_q == S_WAIT) && eng_done && !abort_hit;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    load = 1'b1;
                    // The inputs being latched this edge are the latched counts.
                    state_d = (num_patches == '0 || num_filters == '0) ? S_FINISH : S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (eng_done) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (out_if.out_ready) begin
                    step    = 1'b1;
                    state_d = cnt_last ? S_FINISH : S_LAUNCH;
                end
            end
            S_FINISH: begin
                // A zero-count job enters FINISH straight from IDLE and spends
                // one cycle there before job_done; otherwise done_q is already
                // high on entry and FINISH lasts one cycle.
                if (done_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins over a simultaneous handshake or engine completion.
        if (abort_hit) begin
            state_d = S_IDLE;
            step    = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        // NOTE: synchronous reset lives inside the clocked branch; sequential
        // state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            np_q        <= '0;
            nf_q        <= '0;
            vl_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            eng_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != S_IDLE);
            eng_start_q <= (state_d == S_LAUNCH);
            out_valid_q <= (state_d == S_WRITE);
            done_q      <= (state_d == S_FINISH) && (state_q != S_IDLE);
            aborted_q   <= abort_hit;
            if (load) begin
                np_q <= num_patches;
                nf_q <= num_filters;
                vl_q <= vec_length;
            end
            if (capture) out_data_q <= eng_result;
        end
    end

    dpe_index_counter #(
        .CNT_WIDTH      (CNT_WIDTH),
        .OUT_ADDR_WIDTH (OUT_ADDR_WIDTH)
    ) u_index_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (load),
        .step_i        (step),
        .num_patches_i (np_q),
        .num_filters_i (nf_q),
        .patch_idx_o   (patch_sel),
        .filter_idx_o  (filter_sel),
        .out_addr_o    (out_addr),
        .last_o        (cnt_last)
    );

    assign job_busy         = busy_q;
    assign job_done         = done_q;
    assign job_aborted      = aborted_q;
    assign eng_start        = eng_start_q;
    assign eng_vec_length   = vl_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_addr  = out_addr;

endmodule

// File: tb/tb_dpe_job_scheduler.sv
// tb_dpe_job_scheduler
//   Directed bench for dpe_job_scheduler: engine model with a fixed
//   6-cycle latency, output buffer model with scripted backpressure, and
//   a negedge monitor that logs launches, writes and status pulses with
//   cycle stamps for the checks in the main sequence.
module tb_dpe_job_scheduler;
    import dpe_sched_pkg::*;

    localparam int          DW       = DEF_DATA_WIDTH;
    localparam int          AW       = DEF_ADDR_WIDTH;
    localparam int          CW       = DEF_CNT_WIDTH;
    localparam int          OW       = out_addr_width(DEF_CNT_WIDTH);
    localparam logic [31:0] RES_BASE = 32'h41F0_0000;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic          job_start   = 1'b0;
    logic          job_abort   = 1'b0;
    logic [CW-1:0] num_patches = '0;
    logic [CW-1:0] num_filters = '0;
    logic [AW-1:0] vec_length  = '0;
    logic          job_busy, job_done, job_aborted, eng_start;
    logic [AW-1:0] eng_vec_length;
    logic [CW-1:0] patch_sel, filter_sel;
    logic          eng_done    = 1'b0;
    logic [DW-1:0] eng_result  = '0;

    dpe_job_scheduler_if #(.DATA_WIDTH(DW), .OUT_ADDR_WIDTH(OW)) out_if ();

    dpe_job_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .job_start      (job_start),
        .job_abort      (job_abort),
        .num_patches    (num_patches),
        .num_filters    (num_filters),
        .vec_length     (vec_length),
        .job_busy       (job_busy),
        .job_done       (job_done),
        .job_aborted    (job_aborted),
        .eng_start      (eng_start),
        .eng_vec_length (eng_vec_length),
        .patch_sel      (patch_sel),
        .filter_sel     (filter_sel),
        .eng_done       (eng_done),
        .eng_result     (eng_result),
        .out_if         (out_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            stamp;
        logic [OW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] fsel;
        logic [CW-1:0] psel;
    } rec_t;

    rec_t starts[$];
    rec_t writes[$];
    rec_t stalls[$];
    int   dones[$];
    int   aborts[$];
    int   valid_cnt     = 0;
    int   eng_cnt       = 0;
    int   stall_at      = -1;   // global write index to hold off
    int   stall_len     = 0;
    int   stall_cnt     = 0;
    int   last_stall_at = -1;

    // Monitor, engine model and output-buffer model, all at the negedge.
    always @(negedge clk) begin
        rec_t r;
        r.stamp = cyc;
        r.addr  = out_if.out_addr;
        r.data  = out_if.out_data;
        r.fsel  = filter_sel;
        r.psel  = patch_sel;

        if (eng_done) eng_done = 1'b0;
        if (eng_start) begin
            eng_cnt    = 6;
            eng_result = RES_BASE + 32'(starts.size());
            starts.push_back(r);
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) eng_done = 1'b1;
        end

        if (stall_at != last_stall_at) begin
            stall_cnt     = 0;
            last_stall_at = stall_at;
        end
        if (out_if.out_valid && writes.size() == stall_at && stall_cnt < stall_len) begin
            out_if.out_ready = 1'b0;
            stall_cnt++;
            stalls.push_back(r);
        end else begin
            out_if.out_ready = 1'b1;
        end
        if (out_if.out_valid) valid_cnt++;
        if (out_if.out_valid && out_if.out_ready) writes.push_back(r);
        if (job_done)    dones.push_back(cyc);
        if (job_aborted) aborts.push_back(cyc);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Pulses job_start; n0 is the stamp of the edge that samples it.
    task automatic start_job(input int p, input int f, input int l, output int n0);
        num_patches = CW'(p);
        num_filters = CW'(f);
        vec_length  = AW'(l);
        job_start   = 1'b1;
        cyc_wait(1);
        job_start   = 1'b0;
        n0          = cyc;
    endtask

    task automatic wait_end(input string tag, input int db, input int ab, input int bound);
        int n = 0;
        while (dones.size() == db && aborts.size() == ab && n < bound) begin
            cyc_wait(1);
            n++;
        end
        check({tag, "_end_in_time"}, 32'(n < bound), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},    32'(job_busy), 0);
        check({tag, "_done"},    32'(job_done), 0);
        check({tag, "_aborted"}, 32'(job_aborted), 0);
        check({tag, "_estart"},  32'(eng_start), 0);
        check({tag, "_vlen"},    32'(eng_vec_length), 0);
        check({tag, "_psel"},    32'(patch_sel), 0);
        check({tag, "_fsel"},    32'(filter_sel), 0);
        check({tag, "_valid"},   32'(out_if.out_valid), 0);
        check({tag, "_data"},    out_if.out_data, 0);
        check({tag, "_addr"},    32'(out_if.out_addr), 0);
    endtask

    // Checks a completed p x f job whose log entries begin at sb/wb/db/ab.
    // Write stall_i (job-relative) was held off for stall_n cycles.
    task automatic check_job(input string tag, input int p, input int f, input int n0,
                             input int sb, input int wb, input int db, input int ab,
                             input int stall_i, input int stall_n);
        int n = p * f;
        check({tag, "_n_writes"}, writes.size() - wb, n);
        check({tag, "_n_starts"}, starts.size() - sb, n);
        check({tag, "_n_done"},   dones.size() - db, 1);
        check({tag, "_n_abort"},  aborts.size() - ab, 0);
        if (starts.size() > sb) check({tag, "_start0_at"}, starts[sb].stamp, n0);
        for (int i = 0; i < n; i++) begin
            if (wb + i < writes.size() && sb + i < starts.size()) begin
                check($sformatf("%s_addr%0d", tag, i), 32'(writes[wb+i].addr), i);
                check($sformatf("%s_data%0d", tag, i), writes[wb+i].data, RES_BASE + 32'(sb + i));
                check($sformatf("%s_fsel%0d", tag, i), 32'(starts[sb+i].fsel), i / p);
                check($sformatf("%s_psel%0d", tag, i), 32'(starts[sb+i].psel), i % p);
                check($sformatf("%s_lat%0d", tag, i), writes[wb+i].stamp - starts[sb+i].stamp,
                      (i == stall_i) ? 7 + stall_n : 7);
                if (i + 1 < n && sb + i + 1 < starts.size())
                    check($sformatf("%s_relaunch%0d", tag, i),
                          starts[sb+i+1].stamp, writes[wb+i].stamp + 1);
            end
        end
        if (writes.size() == wb + n && dones.size() > db)
            check({tag, "_done_at"}, dones[db], writes[wb+n-1].stamp + 1);
    endtask

    initial begin
        int n0, sb, wb, db, ab, vb, stb, t;

        // Reset state
        cyc_wait(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        cyc_wait(2);

        // Basic job: P=2, F=2, L=4
        sb = starts.size(); wb = writes.size(); db = dones.size(); ab = aborts.size();
        start_job(2, 2, 4, n0);
        check("basic_busy_n1",   32'(job_busy), 1);
        check("basic_estart_n1", 32'(eng_start), 1);
        check("basic_vlen",      32'(eng_vec_length), 4);
        cyc_wait(1);
        check("basic_estart_one_cycle", 32'(eng_start), 0);
        wait_end("basic", db, ab, 200);
        check("basic_done_pulse", 32'(job_done), 1);
        check("basic_busy_finish", 32'(job_busy), 1);
        cyc_wait(1);
        check("basic_done_clear", 32'(job_done), 0);
        check("basic_busy_clear", 32'(job_busy), 0);
        check_job("basic", 2, 2, n0, sb, wb, db, ab, -1, 0);

        // Backpressure on the 2nd result
        cyc_wait(2);
        sb = starts.size(); wb = writes.size(); db = dones.size(); ab = aborts.size();
        stb = stalls.size();
        stall_at = wb + 1; stall_len = 5;
        start_job(2, 2, 4, n0);
        wait_end("bp", db, ab, 200);
        stall_at = -1;
        check_job("bp", 2, 2, n0, sb, wb, db, ab, 1, 5);
        check("bp_n_stall", stalls.size() - stb, 5);
        for (int i = stb; i < stalls.size(); i++) begin
            check($sformatf("bp_hold_addr%0d", i - stb), 32'(stalls[i].addr), 1);
            check($sformatf("bp_hold_data%0d", i - stb), stalls[i].data, RES_BASE + 32'(sb + 1));
        end
        cyc_wait(2);

        // Zero-count job: P=0, F=3
        sb = starts.size(); db = dones.size(); ab = aborts.size(); vb = valid_cnt;
        start_job(0, 3, 4, n0);
        check("zero_busy_n1",   32'(job_busy), 1);
        check("zero_estart_n1", 32'(eng_start), 0);
        wait_end("zero", db, ab, 20);
        if (dones.size() > db) check("zero_done_at", dones[db], n0 + 1);
        cyc_wait(1);
        check("zero_busy_clear", 32'(job_busy), 0);
        cyc_wait(2);
        check("zero_n_starts", starts.size() - sb, 0);
        check("zero_n_valid",  valid_cnt - vb, 0);
        check("zero_n_done",   dones.size() - db, 1);

        // Busy-time job_start and config changes are ignored: P=3, F=1
        sb = starts.size(); wb = writes.size(); db = dones.size(); ab = aborts.size();
        start_job(3, 1, 4, n0);
        cyc_wait(3);
        num_patches = CW'(5); num_filters = CW'(2); vec_length = AW'(9);
        job_start = 1'b1;
        cyc_wait(1);
        job_start = 1'b0;
        cyc_wait(8);
        job_start = 1'b1;
        cyc_wait(1);
        job_start = 1'b0;
        wait_end("busyin", db, ab, 200);
        check("busyin_vlen_kept", 32'(eng_vec_length), 4);
        check_job("busyin", 3, 1, n0, sb, wb, db, ab, -1, 0);
        cyc_wait(3);
        check("busyin_idle_after", 32'(job_busy), 0);
        check("busyin_no_extra_done", dones.size() - db, 1);

        // Abort in WAIT of the 2nd result
        sb = starts.size(); wb = writes.size(); db = dones.size(); ab = aborts.size();
        start_job(2, 2, 4, n0);
        t = 0;
        while (starts.size() < sb + 2 && t < 100) begin
            cyc_wait(1);
            t++;
        end
        check("abort_2nd_launch_seen", 32'(t < 100), 1);
        cyc_wait(2);
        job_abort = 1'b1;
        cyc_wait(1);
        job_abort = 1'b0;
        check("abort_pulse",  32'(job_aborted), 1);
        check("abort_busy",   32'(job_busy), 0);
        check("abort_valid",  32'(out_if.out_valid), 0);
        cyc_wait(1);
        check("abort_pulse_clear", 32'(job_aborted), 0);
        cyc_wait(10);
        check("abort_n_writes", writes.size() - wb, 1);
        check("abort_n_done",   dones.size() - db, 0);
        check("abort_n_abort",  aborts.size() - ab, 1);
        check("abort_idle",     32'(job_busy), 0);
        sb = starts.size(); wb = writes.size(); db = dones.size(); ab = aborts.size();
        start_job(1, 1, 4, n0);
        wait_end("abort_next", db, ab, 100);
        check_job("abort_next", 1, 1, n0, sb, wb, db, ab, -1, 0);
        cyc_wait(2);

        // Reset for one cycle while WRITE is held by backpressure
        db = dones.size();
        stall_at = writes.size(); stall_len = 3;
        start_job(2, 2, 4, n0);
        t = 0;
        while (!out_if.out_valid && t < 50) begin
            cyc_wait(1);
            t++;
        end
        check("rst_mid_in_write", 32'(out_if.out_valid), 1);
        rst_n = 1'b0;
        cyc_wait(1);
        rst_n = 1'b1;
        stall_at = -1;
        check_outputs_zero("rst_mid");
        cyc_wait(10);
        check("rst_mid_no_done", dones.size() - db, 0);
        check("rst_mid_idle",    32'(job_busy), 0);
        sb = starts.size(); wb = writes.size(); db = dones.size(); ab = aborts.size();
        start_job(2, 1, 4, n0);
        wait_end("rst_next", db, ab, 100);
        check_job("rst_next", 2, 1, n0, sb, wb, db, ab, -1, 0);

        cyc_wait(2);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
